// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared writeback types and register-file constants
package JZJCoreFTypes;

  localparam int REG_COUNT = 32;

  typedef logic [4:0] RegIndex_t;

  localparam RegIndex_t REG_ZERO = 5'd0;

  typedef struct packed {
    RegIndex_t   address;
    logic [31:0] data;
  } WritebackRequest_t;

  // Wrap-around increment used by the round-robin pointer.
  function automatic int wrap_next(input int index, input int count);
    return (index + 1 >= count) ? 0 : index + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - round-robin grant with a rotating priority pointer
module rr_arbiter
  import JZJCoreFTypes::*;
#(
  parameter int N              = 3,
  parameter int RESET_PRIORITY = 0,
  localparam int PW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_index,
  output logic          transfer
);

  logic [PW-1:0] pointer;
  logic [PW-1:0] pointer_next;
  logic [PW:0]   candidate;
  logic          found;

  // Walk the requesters starting at the pointer; the first valid one wins.
  // Gating with reset keeps every grant low while reset is held.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    candidate   = '0;
    for (int k = 0; k < N; k++) begin
      candidate = {1'b0, pointer} + (PW+1)'(k);
      if (candidate >= (PW+1)'(N)) begin
        candidate = candidate - (PW+1)'(N);
      end
      if (!found && reset && valid[candidate[PW-1:0]]) begin
        found                       = 1'b1;
        grant[candidate[PW-1:0]]    = 1'b1;
        grant_index                 = candidate[PW-1:0];
      end
    end
  end

  assign transfer = found;

  always_comb begin
    pointer_next = pointer;
    if (found) begin
      pointer_next = PW'(wrap_next(int'(grant_index), N));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pointer <= PW'(RESET_PRIORITY);
    end else begin
      pointer <= pointer_next;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port and tracks pending writes
module regfile_write_arbiter
  import JZJCoreFTypes::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int RESET_PRIORITY = 0,
  localparam int PW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    reqValid,
  output logic [NUM_REQ-1:0]    reqReady,
  input  logic [NUM_REQ*5-1:0]  reqAddress,
  input  logic [NUM_REQ*32-1:0] reqData,
  output logic [31:0]           rd,
  output logic [4:0]            rdAddress,
  output logic                  rdWriteEnable,
  input  logic                  reserveValid,
  input  logic [4:0]            reserveAddress,
  input  logic [4:0]            rs1Address,
  input  logic [4:0]            rs2Address,
  output logic                  hazardStall,
  output logic [31:0]           busyVector
);

  WritebackRequest_t        requests [NUM_REQ];
  WritebackRequest_t        selected;
  logic [PW-1:0]            grant_index;
  logic                     transfer;
  logic [REG_COUNT-1:0]     busy_next;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      requests[i].address = reqAddress[i*5 +: 5];
      requests[i].data    = reqData[i*32 +: 32];
    end
  end

  rr_arbiter #(
    .N              (NUM_REQ),
    .RESET_PRIORITY (RESET_PRIORITY)
  ) u_rr_arbiter (
    .clock       (clock),
    .reset       (reset),
    .valid       (reqValid),
    .grant       (reqReady),
    .grant_index (grant_index),
    .transfer    (transfer)
  );

  assign selected = requests[grant_index];

  // A write to x0 is still accepted, it just never strobes the register file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd            <= '0;
      rdAddress     <= REG_ZERO;
      rdWriteEnable <= 1'b0;
    end else if (transfer) begin
      rd            <= selected.data;
      rdAddress     <= selected.address;
      rdWriteEnable <= (selected.address != REG_ZERO);
    end else begin
      rdWriteEnable <= 1'b0;
    end
  end

  // Clear happens at the commit edge; applying the set afterwards lets a
  // fresh reservation win over a retiring write to the same register.
  always_comb begin
    busy_next = busyVector;
    if (rdWriteEnable) begin
      busy_next[rdAddress] = 1'b0;
    end
    if (reserveValid && (reserveAddress != REG_ZERO)) begin
      busy_next[reserveAddress] = 1'b1;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busyVector <= '0;
    end else begin
      busyVector <= busy_next;
    end
  end

  assign hazardStall = ((rs1Address != REG_ZERO) && busyVector[rs1Address]) ||
                       ((rs2Address != REG_ZERO) && busyVector[rs2Address]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized checks against a behavioural model
module tb_regfile_write_arbiter;

  localparam int N = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    reqValid = '0;
  logic [N-1:0]    reqReady;
  logic [N*5-1:0]  reqAddress;
  logic [N*32-1:0] reqData;
  logic [31:0]     rd;
  logic [4:0]      rdAddress;
  logic            rdWriteEnable;
  logic            reserveValid = 1'b0;
  logic [4:0]      reserveAddress = '0;
  logic [4:0]      rs1Address = '0;
  logic [4:0]      rs2Address = '0;
  logic            hazardStall;
  logic [31:0]     busyVector;

  logic [4:0]      addr [N];
  logic [31:0]     data [N];

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ptr;
  bit [31:0]   m_busy;
  bit          m_we;
  bit [31:0]   m_rd;
  bit [4:0]    m_addr;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      reqAddress[i*5 +: 5]  = addr[i];
      reqData[i*32 +: 32]   = data[i];
    end
  end

  regfile_write_arbiter #(.NUM_REQ(N), .RESET_PRIORITY(0)) dut (
    .clock          (clock),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqAddress     (reqAddress),
    .reqData        (reqData),
    .rd             (rd),
    .rdAddress      (rdAddress),
    .rdWriteEnable  (rdWriteEnable),
    .reserveValid   (reserveValid),
    .reserveAddress (reserveAddress),
    .rs1Address     (rs1Address),
    .rs2Address     (rs2Address),
    .hazardStall    (hazardStall),
    .busyVector     (busyVector)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_addr = '0;
  endtask

  // Index of the requester that should win this cycle, or -1 for none.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (reqValid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_stall();
    return (rs1Address != 0 && m_busy[rs1Address]) || (rs2Address != 0 && m_busy[rs2Address]);
  endfunction

  // Inputs are set at the falling edge; check combinational outputs,
  // advance the model across the rising edge, then check registered outputs.
  task automatic step();
    int g;
    bit [31:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk("reqReady", 32'(reqReady), exp_ready);
    chk("hazardStall", 32'(hazardStall), 32'(model_stall()));
    @(posedge clock);
    if (m_we) m_busy[m_addr] = 1'b0;
    if (reserveValid && reserveAddress != 0) m_busy[reserveAddress] = 1'b1;
    m_busy[0] = 1'b0;
    if (g >= 0) begin
      m_we   = (addr[g] != 0);
      m_rd   = data[g];
      m_addr = addr[g];
      m_ptr  = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    @(negedge clock);
    chk("rdWriteEnable", 32'(rdWriteEnable), 32'(m_we));
    chk("rdAddress", 32'(rdAddress), 32'(m_addr));
    chk("rd", rd, m_rd);
    chk("busyVector", busyVector, m_busy);
  endtask

  task automatic idle_inputs();
    reqValid     = '0;
    reserveValid = 1'b0;
    reserveAddress = '0;
    rs1Address   = '0;
    rs2Address   = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    model_reset();

    // Reset held for three cycles with every requester asking.
    reset    = 1'b0;
    reqValid = '1;
    repeat (3) begin
      @(negedge clock);
      chk("reset_ready", 32'(reqReady), 32'd0);
      chk("reset_we", 32'(rdWriteEnable), 32'd0);
      chk("reset_busy", busyVector, 32'd0);
    end
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("idle_ready", 32'(reqReady), 32'd0);
    chk("idle_stall", 32'(hazardStall), 32'd0);
    step();

    // Round-robin fairness: grant order 0,1,2 repeating.
    for (int i = 0; i < N; i++) begin
      addr[i] = 5'(i + 1);
      data[i] = 32'h1000_0000 + 32'(i);
    end
    reqValid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_order", 32'(reqReady), 32'd1 << (c % 3));
      step();
      chk("rr_address", 32'(rdAddress), 32'((c % 3) + 1));
    end
    idle_inputs();
    step();

    // Single write latency from requester 0.
    addr[0]  = 5'd5;
    data[0]  = 32'hDEADBEEF;
    reqValid = 3'b001;
    #1;
    chk("lat_ready", 32'(reqReady), 32'd1);
    step();
    chk("lat_we", 32'(rdWriteEnable), 32'd1);
    chk("lat_addr", 32'(rdAddress), 32'd5);
    chk("lat_data", rd, 32'hDEADBEEF);
    reqValid = '0;
    step();
    chk("lat_we_drop", 32'(rdWriteEnable), 32'd0);
    chk("lat_hold", rd, 32'hDEADBEEF);

    // Scoreboard: reserve x7, stall on rs1, then requester 1 retires it.
    reserveValid   = 1'b1;
    reserveAddress = 5'd7;
    step();
    reserveValid = 1'b0;
    rs1Address   = 5'd7;
    step();
    chk("sb_stall", 32'(hazardStall), 32'd1);
    step();
    addr[1]  = 5'd7;
    data[1]  = 32'h0000_0777;
    reqValid = 3'b010;
    step();
    chk("sb_busy_commit", 32'(busyVector[7]), 32'd1);
    reqValid = '0;
    step();
    #1;
    chk("sb_clear", 32'(busyVector[7]), 32'd0);
    chk("sb_unstall", 32'(hazardStall), 32'd0);
    idle_inputs();
    step();

    // x0 write is accepted without strobing the register file.
    addr[2]  = 5'd0;
    data[2]  = 32'hCAFE_0000;
    reqValid = 3'b100;
    #1;
    chk("x0_ready", 32'(reqReady), 32'd4);
    step();
    chk("x0_we", 32'(rdWriteEnable), 32'd0);
    reqValid = '0;

    // Set wins over a same-edge clear of x9.
    reserveValid   = 1'b1;
    reserveAddress = 5'd9;
    step();
    reserveValid = 1'b0;
    addr[1]  = 5'd9;
    data[1]  = 32'h0000_0999;
    reqValid = 3'b010;
    step();
    reqValid       = '0;
    reserveValid   = 1'b1;
    reserveAddress = 5'd9;
    step();
    chk("collide_busy9", 32'(busyVector[9]), 32'd1);
    reserveAddress = 5'd0;
    step();
    chk("reserve_x0", 32'(busyVector[0]), 32'd0);
    idle_inputs();
    step();

    // Reset mid-operation cancels the in-flight write and all reservations.
    reserveValid   = 1'b1;
    reserveAddress = 5'd12;
    addr[1]  = 5'd3;
    data[1]  = 32'h0000_0333;
    reqValid = 3'b010;
    step();
    chk("mid_we_before", 32'(rdWriteEnable), 32'd1);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_we_drop", 32'(rdWriteEnable), 32'd0);
    chk("mid_busy", busyVector, 32'd0);
    chk("mid_ready", 32'(reqReady), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    for (int i = 0; i < N; i++) addr[i] = 5'(i + 1);
    reqValid = '1;
    #1;
    chk("mid_ptr", 32'(reqReady), 32'd1);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reqValid       = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        addr[i] = 5'($urandom_range(0, 31));
        data[i] = $urandom;
      end
      reserveValid   = 1'($urandom_range(0, 1));
      reserveAddress = 5'($urandom_range(0, 31));
      rs1Address     = 5'($urandom_range(0, 31));
      rs2Address     = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
